button_poll_master: RTL and testbench

Avalon-MM read master that polls a 4-bit button input PIO at a fixed interval, debounces the sampled value and emits press/release events through a valid/ready interface. It is the initiator for the SOC's button PIO slave, so a small hardware client can consume button activity without the Nios II polling. It sits in the fabric next to the PIO, on the same clock.

---
 rtl/button_poll_pkg.sv | 18 +
 rtl/button_debounce.sv | 61 ++++++
 rtl/button_poll_master.sv | 167 ++++++++++++++++
 tb/tb_button_poll_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_poll_pkg.sv
// Shared types and defaults for the button PIO poller: FSM states, button count
// and the default parameter values used by the top level and the debouncer.
package button_poll_pkg;

  localparam int         NUM_BTN            = 4;
  localparam int         DEF_POLL_DIV       = 50000;
  localparam int         DEF_STABLE_SAMPLES = 4;
  localparam int         DEF_READ_LATENCY   = 1;
  localparam logic [1:0] DEF_PIO_ADDR       = 2'd0;
  localparam bit         DEF_ACTIVE_LOW     = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2
  } poll_state_e;

endpackage

// File: rtl/button_debounce.sv
// Whole-vector debouncer: a new level is accepted once STABLE_SAMPLES identical
// samples in a row have been seen; emits a one-cycle press/release event.
module button_debounce
  import button_poll_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_sample,
  input  logic               i_sample_stb,
  output logic [NUM_BTN-1:0] o_btn_state,
  output logic               o_evt_new,
  output logic [NUM_BTN-1:0] o_evt_press,
  output logic [NUM_BTN-1:0] o_evt_release
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_SAMPLES);

  logic [NUM_BTN-1:0] r_cand;
  logic [NUM_BTN-1:0] r_btn;
  logic [3:0]         r_cnt;
  logic [NUM_BTN-1:0] w_cand_next;
  logic [3:0]         w_cnt_next;
  logic               w_evt_new;

  always_comb begin
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    if (i_sample_stb) begin
      if (i_sample != r_cand) begin
        w_cand_next = i_sample;
        w_cnt_next  = 4'd1;
      end else if (r_cnt < STABLE_N) begin
        w_cnt_next = r_cnt + 4'd1;
      end
    end
  end

  // Edges are taken against the level being replaced, so both vectors use r_btn.
  assign w_evt_new     = i_sample_stb && (w_cnt_next == STABLE_N) && (w_cand_next != r_btn);
  assign o_evt_new     = w_evt_new;
  assign o_evt_press   = w_cand_next & ~r_btn;
  assign o_evt_release = ~w_cand_next & r_btn;
  assign o_btn_state   = r_btn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
      r_btn  <= '0;
    end else begin
      r_cand <= w_cand_next;
      r_cnt  <= w_cnt_next;
      if (w_evt_new) begin
        r_btn <= w_cand_next;
      end
    end
  end

endmodule

// File: rtl/button_poll_master.sv
// Avalon-MM read master that polls the button PIO on a fixed tick, debounces the
// sampled vector and reports press/release events to a local consumer.
module button_poll_master
  import button_poll_pkg::*;
#(
  parameter int         POLL_DIV       = DEF_POLL_DIV,
  parameter int         STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int         READ_LATENCY   = DEF_READ_LATENCY,
  parameter logic [1:0] PIO_ADDR       = DEF_PIO_ADDR,
  parameter bit         ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               reset,
  output logic [1:0]         avm_address,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [NUM_BTN-1:0] evt_press,
  output logic [NUM_BTN-1:0] evt_release,
  output logic               evt_overflow,
  output logic [1:0]         dbg_state
);

  localparam int                 CNT_W     = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [1:0]         LAT_N     = 2'(READ_LATENCY);
  localparam logic [NUM_BTN-1:0] INV_MASK  = {NUM_BTN{ACTIVE_LOW}};

  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;
  poll_state_e        r_state;
  poll_state_e        w_state_next;
  logic [1:0]         r_lat_cnt;
  logic [1:0]         w_lat_next;
  logic               w_capture;
  logic [NUM_BTN-1:0] r_sample;
  logic               r_sample_stb;
  logic               w_evt_new;
  logic [NUM_BTN-1:0] w_evt_press;
  logic [NUM_BTN-1:0] w_evt_release;
  logic               r_evt_valid;
  logic [NUM_BTN-1:0] r_evt_press;
  logic [NUM_BTN-1:0] r_evt_release;
  logic               r_evt_overflow;
  logic               w_unused_rdata;

  assign w_unused_rdata = ^avm_readdata[31:NUM_BTN];

  // Free-running poll timer; ticks arriving while a read is in flight are lost.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_next;
    end
  end

  // r_lat_cnt holds how many cycles have passed since the read was accepted.
  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat_cnt;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            w_capture    = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_lat_next   = 2'd1;
            w_state_next = LAT;
          end
        end
      end
      LAT: begin
        if (r_lat_cnt == LAT_N) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_lat_next = r_lat_cnt + 2'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign avm_read    = (r_state == REQ);
  assign avm_address = PIO_ADDR;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample     <= '0;
      r_sample_stb <= 1'b0;
    end else begin
      r_sample_stb <= w_capture;
      if (w_capture) begin
        r_sample <= avm_readdata[NUM_BTN-1:0] ^ INV_MASK;
      end
    end
  end

  button_debounce #(
    .STABLE_SAMPLES (STABLE_SAMPLES)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .i_sample      (r_sample),
    .i_sample_stb  (r_sample_stb),
    .o_btn_state   (btn_state),
    .o_evt_new     (w_evt_new),
    .o_evt_press   (w_evt_press),
    .o_evt_release (w_evt_release)
  );

  // Event handshake: an event transfers on a cycle where evt_valid and evt_ready
  // are both high; while evt_valid is high and evt_ready low the payload holds,
  // growing only by OR-merging later events (which also sets evt_overflow).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_valid    <= 1'b0;
      r_evt_press    <= '0;
      r_evt_release  <= '0;
      r_evt_overflow <= 1'b0;
    end else if (w_evt_new) begin
      if (!r_evt_valid || evt_ready) begin
        r_evt_press   <= w_evt_press;
        r_evt_release <= w_evt_release;
        r_evt_valid   <= 1'b1;
      end else begin
        r_evt_press    <= r_evt_press | w_evt_press;
        r_evt_release  <= r_evt_release | w_evt_release;
        r_evt_overflow <= 1'b1;
      end
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign evt_valid    = r_evt_valid;
  assign evt_press    = r_evt_press;
  assign evt_release  = r_evt_release;
  assign evt_overflow = r_evt_overflow;

endmodule

// File: tb/tb_button_poll_master.sv
// Self-checking bench for button_poll_master: transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_button_poll_master;

  localparam int POLL_DIV = 8;
  localparam int STABLE   = 3;
  localparam int LATENCY  = 1;

  logic        clk;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [3:0]  btn_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_press;
  logic [3:0]  evt_release;
  logic        evt_overflow;
  logic [1:0]  dbg_state;

  int checks      = 0;
  int failures    = 0;
  int stall_limit = 0;
  int stall_cnt   = 0;
  int acc_cnt     = 0;

  button_poll_master #(
    .POLL_DIV       (POLL_DIV),
    .STABLE_SAMPLES (STABLE),
    .READ_LATENCY   (LATENCY),
    .PIO_ADDR       (2'd0),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .btn_state       (btn_state),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_press       (evt_press),
    .evt_release     (evt_release),
    .evt_overflow    (evt_overflow),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Avalon slave: stalls each read stall_limit cycles ----------------
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (avm_read && stall_cnt < stall_limit) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        if (!avm_read) stall_cnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } samp_t;

  bit         m_on = 1'b0;
  int         m_c;
  bit         m_req;
  int         m_busy_until;
  int         rd_q[$];
  samp_t      samp_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_btn;
  logic [3:0] m_press;
  logic [3:0] m_release;
  bit         m_valid;
  bit         m_ovf;

  task automatic model_reset();
    m_on         = 1'b1;
    m_c          = 0;
    m_req        = 1'b0;
    m_busy_until = -1;
    rd_q.delete();
    samp_q.delete();
    hist.delete();
    m_btn     = 4'h0;
    m_press   = 4'h0;
    m_release = 4'h0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
  endtask

  function automatic logic [1:0] exp_state();
    if (m_req) return 2'd1;
    if (m_c <= m_busy_until) return 2'd2;
    return 2'd0;
  endfunction

  // Advance the model over the cycle just observed (inputs of cycle m_c).
  task automatic model_step();
    bit         idle;
    bit         new_ev;
    bit         stable;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] v;
    samp_t      s;
    idle   = !m_req && (m_c > m_busy_until);
    new_ev = 1'b0;
    p      = 4'h0;
    r      = 4'h0;
    if (m_req && !avm_waitrequest) begin
      acc_cnt++;
      m_req        = 1'b0;
      m_busy_until = m_c + LATENCY;
      rd_q.push_back(m_c + LATENCY);
    end
    if (rd_q.size() > 0 && rd_q[0] == m_c) begin
      s.cyc = m_c + 1;
      s.val = avm_readdata[3:0] ^ 4'hF;
      samp_q.push_back(s);
      void'(rd_q.pop_front());
    end
    if (samp_q.size() > 0 && samp_q[0].cyc == m_c) begin
      v = samp_q[0].val;
      void'(samp_q.pop_front());
      hist.push_back(v);
      if (hist.size() > STABLE) void'(hist.pop_front());
      stable = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] != v) stable = 1'b0;
      if (stable && v != m_btn) begin
        new_ev = 1'b1;
        p      = v & ~m_btn;
        r      = ~v & m_btn;
        m_btn  = v;
      end
    end
    if (new_ev) begin
      if (!m_valid || evt_ready) begin
        m_press   = p;
        m_release = r;
        m_valid   = 1'b1;
      end else begin
        m_press   = m_press | p;
        m_release = m_release | r;
        m_ovf     = 1'b1;
      end
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    if (idle && (m_c % POLL_DIV == POLL_DIV - 1)) m_req = 1'b1;
    m_c++;
  endtask

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        chk("avm_read", 32'(avm_read), 32'(m_req));
        chk("avm_address", 32'(avm_address), 32'h0);
        chk("fsm_state", 32'(dbg_state), 32'(exp_state()));
        chk("btn_state", 32'(btn_state), 32'(m_btn));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        if (m_valid) begin
          chk("evt_press", 32'(evt_press), 32'(m_press));
          chk("evt_release", 32'(evt_release), 32'(m_release));
        end
      end
      if (reset) model_reset();
      else if (m_on) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_captures(input int n);
    int target;
    int t;
    target = acc_cnt + n;
    t      = 0;
    while (acc_cnt < target && t < 200) begin
      step();
      t++;
    end
    if (acc_cnt < target) chk("capture_timeout", 32'(acc_cnt), 32'(target));
    repeat (LATENCY + 2) step();
  endtask

  task automatic poll_n(input logic [3:0] val, input int n);
    avm_readdata = {28'h0, val};
    wait_captures(n);
  endtask

  task automatic ack();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic measure_read(output int hi);
    int t;
    hi = 0;
    t  = 0;
    @(negedge clk);
    while (avm_read && t < 40) begin
      @(negedge clk);
      t++;
    end
    while (!avm_read && t < 80) begin
      @(negedge clk);
      t++;
    end
    while (avm_read && hi < 20) begin
      hi++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int first;
    int hi;
    int t;
    reset        = 1'b1;
    evt_ready    = 1'b0;
    avm_readdata = 32'hF;
    step();
    step();
    reset = 1'b0;

    chk("rst_avm_read", 32'(avm_read), 32'h0);
    chk("rst_avm_address", 32'(avm_address), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    chk("rst_btn_state", 32'(btn_state), 32'h0);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_evt_press", 32'(evt_press), 32'h0);
    chk("rst_evt_release", 32'(evt_release), 32'h0);
    chk("rst_evt_overflow", 32'(evt_overflow), 32'h0);

    first = -1;
    for (int n = 0; n < 20 && first < 0; n++) begin
      @(negedge clk);
      if (avm_read) first = n;
      else step();
    end
    chk("first_read_cycle", 32'(first), 32'd8);
    chk("first_read_addr", 32'(avm_address), 32'h0);

    stall_limit = 3;
    measure_read(hi);
    chk("stalled_read_cycles", 32'(hi), 32'd4);
    repeat (3) step();
    stall_limit = 0;

    poll_n(4'hE, 3);
    chk("press_btn_state", 32'(btn_state), 32'h1);
    chk("press_evt_valid", 32'(evt_valid), 32'h1);
    chk("press_evt_press", 32'(evt_press), 32'h1);
    chk("press_evt_release", 32'(evt_release), 32'h0);
    ack();
    chk("press_ack_valid", 32'(evt_valid), 32'h0);

    poll_n(4'hF, 3);
    chk("release_btn_state", 32'(btn_state), 32'h0);
    chk("release_evt_release", 32'(evt_release), 32'h1);
    chk("release_evt_press", 32'(evt_press), 32'h0);
    ack();

    poll_n(4'hE, 1);
    poll_n(4'hF, 1);
    poll_n(4'hE, 2);
    chk("bounce_no_event", 32'(evt_valid), 32'h0);
    chk("bounce_btn_hold", 32'(btn_state), 32'h0);
    poll_n(4'hE, 1);
    chk("bounce_evt_valid", 32'(evt_valid), 32'h1);
    chk("bounce_evt_press", 32'(evt_press), 32'h1);
    chk("bounce_evt_release", 32'(evt_release), 32'h0);
    chk("bounce_btn_state", 32'(btn_state), 32'h1);
    ack();

    poll_n(4'hF, 3);
    ack();
    poll_n(4'hE, 3);
    poll_n(4'hF, 3);
    chk("merge_evt_valid", 32'(evt_valid), 32'h1);
    chk("merge_evt_press", 32'(evt_press), 32'h1);
    chk("merge_evt_release", 32'(evt_release), 32'h1);
    chk("merge_overflow", 32'(evt_overflow), 32'h1);
    chk("merge_btn_state", 32'(btn_state), 32'h0);
    ack();
    chk("merge_ack_valid", 32'(evt_valid), 32'h0);
    chk("overflow_sticky", 32'(evt_overflow), 32'h1);

    stall_limit = 10;
    t = 0;
    @(negedge clk);
    while (!(avm_read && avm_waitrequest) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("midread_stalled", 32'(avm_read && avm_waitrequest), 32'h1);
    step();
    reset        = 1'b1;
    avm_readdata = 32'h0;
    step();
    reset       = 1'b0;
    stall_limit = 0;
    chk("midreset_avm_read", 32'(avm_read), 32'h0);
    chk("midreset_state", 32'(dbg_state), 32'h0);
    chk("midreset_overflow", 32'(evt_overflow), 32'h0);
    chk("midreset_btn_state", 32'(btn_state), 32'h0);

    poll_n(4'h0, 2);
    chk("post_reset_btn_hold", 32'(btn_state), 32'h0);
    chk("post_reset_no_event", 32'(evt_valid), 32'h0);
    poll_n(4'h0, 1);
    chk("all_press_btn_state", 32'(btn_state), 32'hF);
    chk("all_press_evt_press", 32'(evt_press), 32'hF);
    chk("all_press_evt_release", 32'(evt_release), 32'h0);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
